// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start, DATA_BITS data bits (LSB first), parity, stop.
// Parity is checked with a running XOR accumulated as the data bits are sampled.
module xor_parity_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic ODD = (ODD_PARITY != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 acc_q, acc_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 sync1_q, sync2_q;
    logic                 rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        shift_d      = shift_q;
        par_d        = par_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                        acc_d   = 1'b0;
                    end else begin
                        // line went back high before mid-bit: a glitch, not a frame
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    for (int i = 0; i < DATA_BITS; i++)
                        if (idx_q == IW'(i)) shift_d[i] = rx_s;
                    acc_d = acc_q ^ rx_s;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_d = PARITY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = acc_q ^ rx_s ^ ODD;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d        = '0;
                    state_d      = IDLE;
                    valid_d      = 1'b1;
                    data_out_d   = shift_q;
                    parity_err_d = par_q;
                    frame_err_d  = ~rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            acc_q        <= 1'b0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx_in;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_xor_parity_rx.sv
// Directed bench for xor_parity_rx: an even-parity and an odd-parity receiver
// share one serial line; completed frames are logged on the falling edge.
module tb_xor_parity_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] data_out, data_out_o;
    logic       valid, parity_err, frame_err, busy;
    logic       valid_o, parity_err_o, frame_err_o, busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int ocnt = 0;
    int   vc[16];
    logic [7:0] vd[16];
    logic vpe[16], vfe[16], ope[16];

    xor_parity_rx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .ODD_PARITY(0)) u_even (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(data_out), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy));

    xor_parity_rx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .ODD_PARITY(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(data_out_o), .valid(valid_o),
        .parity_err(parity_err_o), .frame_err(frame_err_o), .busy(busy_o));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && vcnt < 16) begin
            vc[vcnt]  = cyc;
            vd[vcnt]  = data_out;
            vpe[vcnt] = parity_err;
            vfe[vcnt] = frame_err;
            vcnt++;
        end
        if (valid_o && ocnt < 16) begin
            ope[ocnt] = parity_err_o;
            ocnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_cell(input logic b);
        rx_in = b;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp);
        bit_cell(1'b0);
        for (int i = 0; i < 8; i++) bit_cell(d[i]);
        bit_cell(par);
        bit_cell(stp);
        rx_in = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int c0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // good frame 0xA5, even parity bit 0
        c0 = cyc;
        send(8'hA5, 1'b0, 1'b1);
        idle(6);
        chk("good_cnt", 32'(vcnt), 32'd1);
        chk("good_lat", 32'(vc[0] - c0), 32'd45);
        chk("good_data", 32'(vd[0]), 32'hA5);
        chk("good_perr", 32'(vpe[0]), 32'h0);
        chk("good_ferr", 32'(vfe[0]), 32'h0);
        chk("good_odd_perr", 32'(ope[0]), 32'h1);
        chk("good_busy", 32'(busy), 32'h0);

        // 0x07 has three ones: parity 0 is wrong for even, right for odd
        send(8'h07, 1'b0, 1'b1);
        idle(6);
        chk("par_cnt", 32'(vcnt), 32'd2);
        chk("par_data", 32'(vd[1]), 32'h07);
        chk("par_perr", 32'(vpe[1]), 32'h1);
        chk("par_odd_perr", 32'(ope[1]), 32'h0);

        // low stop bit
        send(8'h3C, 1'b0, 1'b0);
        idle(10);
        chk("frm_cnt", 32'(vcnt), 32'd3);
        chk("frm_data", 32'(vd[2]), 32'h3C);
        chk("frm_ferr", 32'(vfe[2]), 32'h1);
        chk("frm_perr", 32'(vpe[2]), 32'h0);
        chk("frm_busy", 32'(busy), 32'h0);

        // one-cycle glitch
        rx_in = 1'b0;
        @(negedge clk);
        idle(3);
        chk("gl_busy_hi", 32'(busy), 32'h1);
        idle(8);
        chk("gl_cnt", 32'(vcnt), 32'd3);
        chk("gl_busy", 32'(busy), 32'h0);
        chk("gl_data", 32'(data_out), 32'h3C);

        // reset during data bit 4 of 0xFF
        bit_cell(1'b0);
        for (int i = 0; i < 4; i++) bit_cell(1'b1);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_data", 32'(data_out), 32'h0);
        chk("mid_busy_rst", 32'(busy), 32'h0);
        chk("mid_ferr", 32'(frame_err), 32'h0);
        chk("mid_valid", 32'(valid), 32'h0);
        idle(30);
        rst_n = 1'b1;
        idle(4);
        chk("mid_cnt", 32'(vcnt), 32'd3);
        send(8'h3C, 1'b0, 1'b1);
        idle(6);
        chk("post_cnt", 32'(vcnt), 32'd4);
        chk("post_data", 32'(vd[3]), 32'h3C);
        chk("post_perr", 32'(vpe[3]), 32'h0);
        chk("post_ferr", 32'(vfe[3]), 32'h0);

        // back-to-back frames, no idle gap
        send(8'h01, 1'b1, 1'b1);
        send(8'hFE, 1'b1, 1'b1);
        idle(8);
        chk("b2b_cnt", 32'(vcnt), 32'd6);
        chk("b2b_data0", 32'(vd[4]), 32'h01);
        chk("b2b_data1", 32'(vd[5]), 32'hFE);
        chk("b2b_gap", 32'(vc[5] - vc[4]), 32'd44);
        chk("b2b_err0", 32'({vpe[4], vfe[4]}), 32'h0);
        chk("b2b_err1", 32'({vpe[5], vfe[5]}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xor_parity_rx.md
# xor_parity_rx

Serial frame receiver that checks parity by running-XOR accumulation. It is the receiving end of the team's XOR-based parity transmit path. It takes an asynchronous, idle-high serial line and recovers each frame: a start bit, DATA_BITS data bits sent LSB first, one parity bit and one stop bit. Each completed frame is presented as a parallel word with parity-error and framing-error flags and a single-cycle valid strobe.

## Interface
- DATA_BITS, 8: data bits per frame; must be 1..16.
- CLKS_PER_BIT, 4: clk cycles per serial bit; must be at least 2.
- ODD_PARITY, 0: selects parity sense. 0 = even parity, 1 = odd parity.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  DATA_BITS  last received data word; holds its value until the next frame completes.
- valid  output  1  one-cycle pulse marking a completed frame.
- parity_err  output  1  parity flag for the frame in data_out; updates only with valid.
- frame_err  output  1  stop-bit flag for the frame in data_out; updates only with valid.
- busy  output  1  high in every state except IDLE.

## Operation
- rx_in passes through a 2-flop synchronizer. The synchronized signal is rx_s, and all logic uses rx_s only.
- FSM states are IDLE, START, DATA, PARITY and STOP.
  - IDLE: when rx_s = 0, go to START and clear the bit counter. Otherwise stay in IDLE.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s.
    - If 0, go to DATA and clear the bit index and the XOR accumulator.
    - If 1, treat it as a false start and return to IDLE with no valid pulse.
  - DATA: sample once every CLKS_PER_BIT cycles. Shift the sample into bit position index (LSB first) and XOR it into the accumulator. After DATA_BITS samples, go to PARITY.
  - PARITY: take one sample CLKS_PER_BIT cycles later. parity_err_next = (acc ^ sample) ^ ODD_PARITY.
    - Even mode: a correct frame has an even total count of ones across data and parity.
    - Odd mode: a correct frame has an odd total count.
  - STOP: take one sample CLKS_PER_BIT cycles later. frame_err_next = ~sample. Then go to IDLE.
- Valid pulse: in the cycle after the stop sample, valid = 1 for exactly one cycle. In the same cycle, data_out, parity_err and frame_err load their new values.
  - valid asserts even when either error flag is set.
  - A frame with an error still delivers its data word.
- A frame with a bad stop bit does not resynchronize specially. The FSM returns to IDLE and waits for rx_s = 0. A low stop bit therefore immediately looks like a new start.
- Arithmetic:
  - The bit counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 on every sample.
  - The data index is wide enough for DATA_BITS.
  - No other counter wraps.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE; counters = 0; data_out = 0; valid = 0; parity_err = 0; frame_err = 0; busy = 0; both synchronizer flops = 1.
  - Reset that arrives mid-frame abandons the frame with no valid pulse.
  - Reception resumes on the first rx_s low after rst_n returns high.
- Let E be the first rising edge at which rx_s = 0 in IDLE.
- Sample points fall on edge E + CLKS_PER_BIT/2 + k·CLKS_PER_BIT:
  - k = 0: start bit
  - k = 1..DATA_BITS: data bits
  - k = DATA_BITS+1: parity bit
  - k = DATA_BITS+2: stop bit
- valid is high for the single cycle following the stop sample.
- Input-to-state latency is 2 cycles from rx_in to rx_s.
- The FSM is in IDLE on the cycle valid is high, so a new start bit sampled that cycle is accepted: back-to-back frames need zero idle cycles.
- busy:
  - Rises on the cycle after E.
  - Falls when the FSM re-enters IDLE, which is the cycle valid is high or the cycle after a false start.

## Test plan
All scenarios use DATA_BITS = 8, CLKS_PER_BIT = 4 and ODD_PARITY = 0 unless stated otherwise.

- **Good frame:** send 0xA5 with parity 0 and stop 1 -> one valid pulse; data_out = 0xA5; parity_err = 0; frame_err = 0; valid occurs 10·4+2 cycles after E.
- **Parity error:** send 0x07 with parity 0 -> valid; data_out = 0x07; parity_err = 1. Repeat with ODD_PARITY = 1 and parity 0 -> parity_err = 0.
- **Framing error:** send 0x3C with parity 0 and stop 0 -> valid; data_out = 0x3C; frame_err = 1; parity_err = 0.
- **Glitch rejection:** drive rx_in low for 1 cycle, then idle -> no valid pulse; busy returns to 0; data_out keeps its previous value.
- **Reset mid-frame:** assert rst_n low during data bit 4 of 0xFF -> all outputs go to 0 immediately and no valid pulse appears. After release, a frame of 0x3C -> data_out = 0x3C with no errors.
- **Back-to-back frames:** send 0x01 (parity 1), then 0xFE (parity 1) with no idle gap -> two valid pulses exactly 44 cycles apart; data_out = 0x01 then 0xFE; no errors.
